gpio_serial_loader: RTL and testbench

Sequencer that programs the per-pad configuration of the user GPIO pads in the padframe. It shifts a snapshot of every digital pad's configuration word serially into the daisy-chained pad control blocks. It then pulses a load strobe so all pads update together. It sits in housekeeping, between the configuration register file and the mprj pad control chain.

---
 rtl/gpio_serial_loader_pkg.sv | 26 ++
 rtl/gpio_serial_clkgen.sv | 44 ++++
 rtl/gpio_serial_loader.sv | 131 +++++++++++++
 tb/tb_gpio_serial_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_serial_loader_pkg.sv
// Shared types and constants for the GPIO pad configuration loader.
// Pad counts and busy-length helper used by RTL and bench alike.
package gpio_serial_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } ser_state_t;

  localparam int SER_CFG_BITS    = 13;
  localparam int SER_TOTAL_PADS  = 38;
  localparam int SER_ANALOG_PADS = 11;
  localparam int SER_NUM_PADS    =
    SER_TOTAL_PADS - SER_ANALOG_PADS;

  function automatic int ser_busy_cycles(
    input int div,
    input int n
  );
    return 2 * div * n + div;
  endfunction

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Phase timer and serial_clock generator for the pad chain loader.
// Each phase lasts DIV cycles; phase_end marks its last cycle.
module gpio_serial_clkgen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic lo_phase,
  output logic phase_end,
  output logic serial_clock
);

  localparam int PW = $clog2(DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  // Count cycles within the current phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || phase_end) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Clock goes high after a low phase, low after anything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serial_clock <= 1'b0;
    end else if (clr) begin
      serial_clock <= 1'b0;
    end else if (phase_end) begin
      serial_clock <= lo_phase;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Serially programs the user GPIO pad control chain, then strobes
// serial_load so every pad picks up its new word at once.
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int NUM_PADS = SER_NUM_PADS,
  parameter int CFG_BITS = SER_CFG_BITS,
  parameter int DIV      = 1,
  parameter int AUTOLOAD = 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_PADS*CFG_BITS-1:0] cfg_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         serial_clock,
  output logic                         serial_data_out,
  output logic                         serial_load,
  output logic                         serial_resetn
);

  localparam int N  = NUM_PADS * CFG_BITS;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  ser_state_t    state;
  ser_state_t    state_n;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shreg_n;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_n;
  logic          auto_armed;
  logic          accept;
  logic          phase_end;
  logic          busy_n;
  logic          done_n;
  logic          load_n;
  logic          sdo_n;

  // Autoload only counts on the first cycle the chain is out of reset.
  assign accept = ((state == IDLE) || (state == DONE)) &&
                  (start || (auto_armed && serial_resetn));

  gpio_serial_clkgen #(
    .DIV(DIV)
  ) u_clkgen (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .clr         (accept),
    .en          (busy),
    .lo_phase    (state == SHIFT_LO),
    .phase_end   (phase_end),
    .serial_clock(serial_clock)
  );

  // Next state, shift data and the registered output values.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          state_n = SHIFT_LO;
          shreg_n = cfg_data;
          bit_n   = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_end) state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_cnt < LAST_BIT) begin
            state_n = SHIFT_LO;
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shreg << 1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (phase_end) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT_LO) ||
             (state_n == SHIFT_HI) ||
             (state_n == LOAD);
    done_n = (state_n == DONE);
    load_n = (state_n == LOAD);
    sdo_n  = ((state_n == SHIFT_LO) ||
              (state_n == SHIFT_HI)) && shreg_n[N-1];
  end

  // Sequencer state, shift register and registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      serial_load     <= 1'b0;
      serial_data_out <= 1'b0;
    end else begin
      state           <= state_n;
      shreg           <= shreg_n;
      bit_cnt         <= bit_n;
      busy            <= busy_n;
      done            <= done_n;
      serial_load     <= load_n;
      serial_data_out <= sdo_n;
    end
  end

  // Chain reset release and the one-shot autoload arm.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      serial_resetn <= 1'b0;
      auto_armed    <= (AUTOLOAD != 0);
    end else begin
      serial_resetn <= 1'b1;
      if (serial_resetn) auto_armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: offset-based output model, pad chain
// model, and directed plus randomized load scenarios.
`timescale 1ns/1ps
module tb_gpio_serial_loader;
  import gpio_serial_loader_pkg::*;

  localparam int NA  = 27;
  localparam int CA  = 13;
  localparam int DA  = 1;
  localparam int N_A = NA * CA;
  localparam int NB  = 2;
  localparam int CB  = 4;
  localparam int DB  = 3;
  localparam int N_B = NB * CB;
  localparam int TA  = 2 * DA * N_A + DA;
  localparam int TB  = 2 * DB * N_B + DB;

  typedef struct packed {
    logic busy;
    logic done;
    logic sclk;
    logic sdo;
    logic load;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic           rst_a, start_a;
  logic [N_A-1:0] cfg_a;
  logic           busy_a, done_a, sclk_a, sdo_a, load_a, rn_a;
  logic           rst_b, start_b;
  logic [N_B-1:0] cfg_b;
  logic           busy_b, done_b, sclk_b, sdo_b, load_b, rn_b;

  gpio_serial_loader #(
    .NUM_PADS(NA), .CFG_BITS(CA), .DIV(DA), .AUTOLOAD(1)
  ) dut_a (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst_a),
    .cfg_data       (cfg_a),
    .start          (start_a),
    .busy           (busy_a),
    .done           (done_a),
    .serial_clock   (sclk_a),
    .serial_data_out(sdo_a),
    .serial_load    (load_a),
    .serial_resetn  (rn_a)
  );

  gpio_serial_loader #(
    .NUM_PADS(NB), .CFG_BITS(CB), .DIV(DB), .AUTOLOAD(0)
  ) dut_b (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst_b),
    .cfg_data       (cfg_b),
    .start          (start_b),
    .busy           (busy_b),
    .done           (done_b),
    .serial_clock   (sclk_b),
    .serial_data_out(sdo_b),
    .serial_load    (load_b),
    .serial_resetn  (rn_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outputs at offset c of a sequence: bit c/(2*div) is on the line,
  // clock high in the second half of each bit, then load, then done.
  function automatic out_t model_out(
    input int div, input int n, input logic act,
    input int c, input logic [N_A-1:0] snap
  );
    out_t o;
    int   t;
    o = '0;
    t = 2 * div * n + div;
    if (act) begin
      if (c < 2 * div * n) begin
        o.busy = 1'b1;
        o.sclk = (c % (2 * div)) >= div;
        o.sdo  = snap[n - 1 - c / (2 * div)];
      end else if (c < t) begin
        o.busy = 1'b1;
        o.load = 1'b1;
      end else begin
        o.done = 1'b1;
      end
    end
    return o;
  endfunction

  logic           ma_rn, ma_auto, ma_act;
  int             ma_c;
  logic [N_A-1:0] ma_snap;
  logic           mb_rn, mb_auto, mb_act;
  int             mb_c;
  logic [N_A-1:0] mb_snap;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ma_rn <= 1'b0; ma_auto <= 1'b1;
      ma_act <= 1'b0; ma_c <= 0;
    end else begin
      if ((!ma_act || ma_c == TA) &&
          (start_a || (ma_auto && ma_rn))) begin
        ma_act <= 1'b1; ma_c <= 0; ma_snap <= cfg_a;
      end else if (ma_act) begin
        if (ma_c == TA) ma_act <= 1'b0;
        else ma_c <= ma_c + 1;
      end
      if (ma_rn) ma_auto <= 1'b0;
      ma_rn <= 1'b1;
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      mb_rn <= 1'b0; mb_auto <= 1'b0;
      mb_act <= 1'b0; mb_c <= 0;
    end else begin
      if ((!mb_act || mb_c == TB) &&
          (start_b || (mb_auto && mb_rn))) begin
        mb_act <= 1'b1; mb_c <= 0;
        mb_snap <= N_A'(cfg_b);
      end else if (mb_act) begin
        if (mb_c == TB) mb_act <= 1'b0;
        else mb_c <= mb_c + 1;
      end
      if (mb_rn) mb_auto <= 1'b0;
      mb_rn <= 1'b1;
    end
  end

  always @(negedge clk) begin
    out_t ea, eb;
    ea = model_out(DA, N_A, ma_act, ma_c, ma_snap);
    eb = model_out(DB, N_B, mb_act, mb_c, mb_snap);
    chk("a_busy", busy_a, ea.busy);
    chk("a_done", done_a, ea.done);
    chk("a_sclk", sclk_a, ea.sclk);
    chk("a_sdo", sdo_a, ea.sdo);
    chk("a_load", load_a, ea.load);
    chk("a_resetn", rn_a, ma_rn);
    chk("b_busy", busy_b, eb.busy);
    chk("b_done", done_b, eb.done);
    chk("b_sclk", sclk_b, eb.sclk);
    chk("b_sdo", sdo_b, eb.sdo);
    chk("b_load", load_b, eb.load);
    chk("b_resetn", rn_b, mb_rn);
  end

  // Downstream pad chain: shifts in at pad 0 on serial_clock rise,
  // latches all pads on serial_load rise, cleared by serial_resetn.
  logic [N_A-1:0] chain_a, pads_a;
  logic [N_B-1:0] chain_b, pads_b;
  int             rise_a = 0;
  logic           q_b[$];

  always @(posedge sclk_a or negedge rn_a)
    if (!rn_a) chain_a <= '0;
    else chain_a <= {chain_a[N_A-2:0], sdo_a};
  always @(posedge load_a or negedge rn_a)
    if (!rn_a) pads_a <= '0;
    else pads_a <= chain_a;
  always @(posedge sclk_a) rise_a <= rise_a + 1;

  always @(posedge sclk_b or negedge rn_b)
    if (!rn_b) chain_b <= '0;
    else chain_b <= {chain_b[N_B-2:0], sdo_b};
  always @(posedge load_b or negedge rn_b)
    if (!rn_b) pads_b <= '0;
    else pads_b <= chain_b;
  always @(posedge sclk_b) q_b.push_back(sdo_b);

  task automatic check_pads_a(input string nm,
                              input logic [N_A-1:0] exp);
    for (int k = 0; k < NA; k++)
      chk(nm, 64'(pads_a[k*CA +: CA]), 64'(exp[k*CA +: CA]));
  endtask

  task automatic wait_done_a(input string nm);
    int c;
    c = 0;
    while (!done_a && c < ser_busy_cycles(DA, N_A) + 20) begin
      @(negedge clk);
      c++;
    end
    chk(nm, done_a, 1'b1);
  endtask

  task automatic wait_done_b(input string nm);
    int c;
    c = 0;
    while (!done_b && c < ser_busy_cycles(DB, N_B) + 20) begin
      @(negedge clk);
      c++;
    end
    chk(nm, done_b, 1'b1);
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_A-1:0] words, orig;
    logic [7:0]     exp_bits;
    int cnt, lc, run, maxrun, hi, dc;

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < NA; k++) words[k*CA +: CA] = CA'(k);
    cfg_a = words;
    cfg_b = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_resetn", rn_a, 1'b0);
    chk("rst_sdo", sdo_a, 1'b0);

    // Autoload after reset release.
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("t1_resetn_rise", rn_a, 1'b1);
    chk("t1_idle_first", busy_a, 1'b0);
    @(negedge clk);
    chk("t1_autoload", busy_a, 1'b1);
    cnt = 0;
    while (busy_a && cnt < TA + 10) begin
      cnt++;
      @(negedge clk);
    end
    chk("t1_busy_len", cnt, 703);
    chk("t1_done", done_a, 1'b1);
    @(negedge clk);
    chk("t1_done_once", done_a, 1'b0);
    check_pads_a("t1_pad", words);

    // Slow chain, known pattern.
    q_b.delete();
    pulse_b();
    cnt = 0; lc = 0; run = 0; maxrun = 0; hi = 0;
    while (busy_b && cnt < 200) begin
      cnt++;
      if (load_b) lc++;
      if (sclk_b) begin run++; hi++; end
      else run = 0;
      if (run > maxrun) maxrun = run;
      @(negedge clk);
    end
    chk("t2_busy_len", cnt, 51);
    chk("t2_load_len", lc, 3);
    chk("t2_hi_run", maxrun, 3);
    chk("t2_hi_total", hi, 24);
    chk("t2_done", done_b, 1'b1);
    chk("t2_nbits", q_b.size(), 8);
    exp_bits = 8'b1010_0101;
    for (int i = 0; i < 8 && i < q_b.size(); i++)
      chk("t2_bit", q_b[i], exp_bits[7-i]);
    chk("t2_pads", pads_b, 8'hA5);

    // Start held during busy is not queued.
    cfg_b = N_B'($urandom);
    start_b = 1'b1;
    @(negedge clk);
    dc = 0;
    for (int i = 0; i < TB + 10; i++) begin
      start_b = busy_b;
      if (done_b) dc++;
      @(negedge clk);
    end
    start_b = 1'b0;
    chk("t3_one_done", dc, 1);
    chk("t3_pads", pads_b, cfg_b);

    // Start on the done cycle chains a second load.
    orig = N_A'(cfg_b);
    pulse_b();
    wait_done_b("t4_done1");
    chk("t4_pads1", pads_b, orig[N_B-1:0]);
    cfg_b = N_B'($urandom);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("t4_busy_next", busy_b, 1'b1);
    chk("t4_no_done", done_b, 1'b0);
    cnt = 0;
    while (busy_b && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_busy_len", cnt, TB);
    chk("t4_done2", done_b, 1'b1);
    chk("t4_pads2", pads_b, cfg_b);

    // Random loads with random idle gaps.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      cfg_b = N_B'($urandom);
      pulse_b();
      wait_done_b("rnd_done");
      chk("rnd_pads", pads_b, cfg_b);
    end

    // Snapshot is immune to later cfg changes.
    for (int i = 0; i < N_A; i++) cfg_a[i] = 1'($urandom_range(0, 1));
    orig = cfg_a;
    pulse_a();
    repeat (4) @(negedge clk);
    cfg_a = '1;
    wait_done_a("t6_done1");
    @(negedge clk);
    check_pads_a("t6_snap", orig);
    pulse_a();
    wait_done_a("t6_done2");
    @(negedge clk);
    check_pads_a("t6_ones", '1);

    // Reset in the middle of a load.
    cfg_a = words;
    pulse_a();
    rise_a = 0;
    cnt = 0;
    while (rise_a < 100 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_reached_bit", rise_a >= 100, 1'b1);
    #2 rst_a = 1'b1;
    #1;
    chk("t5_busy0", busy_a, 1'b0);
    chk("t5_done0", done_a, 1'b0);
    chk("t5_sclk0", sclk_a, 1'b0);
    chk("t5_sdo0", sdo_a, 1'b0);
    chk("t5_load0", load_a, 1'b0);
    chk("t5_resetn0", rn_a, 1'b0);
    chk("t5_chain_clr", pads_a, '0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    wait_done_a("t5_reload");
    @(negedge clk);
    check_pads_a("t5_pad", words);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
